// File: rtl/serial_arith_pkg.sv
// Shared encodings for the bit-serial arithmetic family (adders and subtractors):
// framing FSM states and the one-bit borrow/carry state values.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic BORROW_0 = 1'b0;
  localparam logic BORROW_1 = 1'b1;

endpackage

// File: rtl/serial_sub_cell.sv
// One-bit serial subtractor cell: registered borrow state plus the combinational
// difference / next-borrow equations for the current operand bit pair.
module serial_sub_cell
  import serial_arith_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic d,
  output logic borrow
);

  logic borrow_next;

  always_comb begin
    d           = a ^ b ^ borrow;
    borrow_next = (~a & b) | (~(a ^ b) & borrow);
  end

  // Clear wins over enable so a freshly accepted word never inherits a stale borrow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      borrow <= BORROW_0;
    end else if (clr) begin
      borrow <= BORROW_0;
    end else if (en) begin
      borrow <= borrow_next;
    end
  end

endmodule

// File: rtl/serial_subtractor_word.sv
// Word-framed bit-serial subtractor computing a_in - b_in LSB first.
// Optional two's-complement overflow output enabled by SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor_word
  import serial_arith_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             bit_valid,
  output logic             diff_bit,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [CNT_W-1:0] cnt;
  logic             cell_d;
  logic             borrow;
  logic             accept;
  logic             shifting;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             a_msb;
  logic             b_msb;
`endif

  assign accept   = (state == ST_IDLE) && start;
  assign shifting = (state == ST_SHIFT);

  serial_sub_cell u_cell (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .en     (shifting),
    .a      (a_sr[0]),
    .b      (b_sr[0]),
    .d      (cell_d),
    .borrow (borrow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      bit_valid  <= 1'b0;
      diff_bit   <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      ovf        <= 1'b0;
`endif
    end else begin
      bit_valid <= 1'b0;
      diff_bit  <= 1'b0;
      done      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sr  <= a_in;
            b_sr  <= b_in;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          bit_valid <= 1'b1;
          diff_bit  <= cell_d;
          diff      <= {cell_d, diff[WIDTH-1:1]};
          a_sr      <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr      <= {1'b0, b_sr[WIDTH-1:1]};
          cnt       <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            state <= ST_DONE;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb <= a_sr[0];
            b_msb <= b_sr[0];
`endif
          end
        end
        ST_DONE: begin
          // diff already holds the full word; its MSB is the final difference bit.
          done       <= 1'b1;
          borrow_out <= borrow;
`ifdef SERIAL_SUB_OVERFLOW_EN
          ovf        <= (a_msb != b_msb) && (diff[WIDTH-1] != a_msb);
`endif
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
